serial_collector: RTL and testbench

SERIAL_COLLECTOR -- requirements
Module: serial_collector

---
 rtl/serial_collector.sv | 131 +++++++++++++
 tb/tb_serial_collector.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_collector.sv
// rtl/serial_collector.sv - bit-serial lane collector assembling WL-bit words into ping-pong row buffers.
// Each lane shifts MSB-first; a completed group is extended to WL bits and handed out as one row.

module serial_collector #(
    parameter int WL              = 16,
    parameter int WORDS_PER_BRICK = 16,
    parameter int BRICKS_PER_ROW  = 16,
    parameter int SW              = WORDS_PER_BRICK * BRICKS_PER_ROW,
    parameter int RL              = WL * SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] i_stream,
    input  logic          i_valid,
    input  logic          i_start,
    input  logic [4:0]    i_prec,
    input  logic          i_signed,
    output logic          o_ready,
    output logic [RL-1:0] o_row,
    output logic          o_row_valid,
    input  logic          i_row_ready,
    output logic          o_err
);

    localparam int CW = $clog2(WL) + 1;
    localparam int IW = $clog2(WL);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          prec_q, prec_d;
    logic                   sgn_q, sgn_d;
    logic [1:0][RL-1:0]     rows_q;
    logic [1:0]             full_q;
    logic                   wr_ptr_q, rd_ptr_q;
    logic                   err_q;

    logic                   accept, load, complete, xfer;
    logic [CW-1:0]          prec_in, prec_cur, count_new;
    logic [IW-1:0]          prec_m1;
    logic                   sgn_cur;
    logic [WL-1:0]          word;
    logic [RL-1:0]          row_next;

    assign o_ready     = (state_q == FILL) || !full_q[wr_ptr_q];
    assign accept      = i_valid && o_ready;
    assign load        = accept && (i_start || (state_q == FILL));
    assign xfer        = full_q[rd_ptr_q] && i_row_ready;
    assign o_row_valid = full_q[rd_ptr_q];
    assign o_row       = full_q[rd_ptr_q] ? rows_q[rd_ptr_q] : '0;
    assign o_err       = err_q;

    always_comb begin
        if (i_prec == 5'd0)
            prec_in = CW'(1);
        else if (int'(i_prec) > WL)
            prec_in = CW'(WL);
        else
            prec_in = CW'(i_prec);
    end

    // A start beat always takes its precision and sign mode from the inputs, even mid-group.
    assign prec_cur  = i_start ? prec_in : prec_q;
    assign sgn_cur   = i_start ? i_signed : sgn_q;
    assign count_new = i_start ? CW'(1) : count_q + CW'(1);
    assign complete  = load && (count_new == prec_cur);
    assign prec_m1   = IW'(prec_cur - CW'(1));

    always_comb begin
        row_next = rows_q[wr_ptr_q];
        word     = '0;
        for (int k = 0; k < SW; k++) begin
            word = i_start ? '0 : rows_q[wr_ptr_q][k*WL +: WL];
            word = {word[WL-2:0], i_stream[k]};
            if (complete) begin
                for (int j = 0; j < WL; j++) begin
                    if (j >= int'(prec_cur))
                        word[j] = sgn_cur & word[prec_m1];
                end
            end
            row_next[k*WL +: WL] = word;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prec_d  = prec_q;
        sgn_d   = sgn_q;
        if (load) begin
            count_d = complete ? '0 : count_new;
            prec_d  = prec_cur;
            sgn_d   = sgn_cur;
            state_d = complete ? IDLE : FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            prec_q   <= '0;
            sgn_q    <= 1'b0;
            rows_q   <= '0;
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prec_q  <= prec_d;
            sgn_q   <= sgn_d;
            if (load)
                rows_q[wr_ptr_q] <= row_next;
            // Completion and transfer never target the same buffer, so both may land together.
            if (complete) begin
                full_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (xfer) begin
                full_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= ~rd_ptr_q;
            end
            if ((i_valid && !o_ready) || (accept && (state_q == IDLE) && !i_start))
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_collector.sv
// tb/tb_serial_collector.sv - scoreboard bench for serial_collector with four 16-bit lanes.

module tb_serial_collector;

    localparam int WL  = 16;
    localparam int WPB = 2;
    localparam int BPR = 2;
    localparam int SW  = WPB * BPR;
    localparam int RL  = WL * SW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] i_stream = '0;
    logic          i_valid = 1'b0;
    logic          i_start = 1'b0;
    logic [4:0]    i_prec = '0;
    logic          i_signed = 1'b0;
    logic          o_ready;
    logic [RL-1:0] o_row;
    logic          o_row_valid;
    logic          i_row_ready = 1'b1;
    logic          o_err;

    int total = 0;
    int bad   = 0;
    logic [RL-1:0] exp_q[$];

    serial_collector #(
        .WL(WL), .WORDS_PER_BRICK(WPB), .BRICKS_PER_ROW(BPR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_stream(i_stream), .i_valid(i_valid),
        .i_start(i_start), .i_prec(i_prec), .i_signed(i_signed),
        .o_ready(o_ready), .o_row(o_row), .o_row_valid(o_row_valid),
        .i_row_ready(i_row_ready), .o_err(o_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [RL-1:0] act, input logic [RL-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Lane k occupies bits [16k+15:16k], matching the row layout.
    function automatic logic [RL-1:0] mk(input logic [15:0] w0, input logic [15:0] w1,
                                         input logic [15:0] w2, input logic [15:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [SW-1:0] bits_at(input logic [RL-1:0] lanes, input int idx);
        logic [SW-1:0] b;
        for (int k = 0; k < SW; k++) b[k] = lanes[k*WL + idx];
        return b;
    endfunction

    task automatic beat(input logic [SW-1:0] s, input logic st, input logic [4:0] p, input logic sg);
        i_stream = s; i_start = st; i_prec = p; i_signed = sg; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_start = 1'b0;
    endtask

    task automatic send(input logic [4:0] p, input logic sg, input logic [RL-1:0] lanes,
                        input int nb, input int upto);
        for (int b = 0; b < upto; b++) beat(bits_at(lanes, nb - 1 - b), b == 0, p, sg);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && o_row_valid && i_row_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_row: got %h expected none", o_row);
            end else begin
                check("row", o_row, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [RL-1:0] l, r1, r2, ra, rb;
        #12;
        check("rst_ready", o_ready, 1);
        check("rst_row_valid", o_row_valid, 0);
        check("rst_row", o_row, 0);
        check("rst_err", o_err, 0);
        rst_n = 1'b1;
        cycles(1);

        exp_q.push_back(mk(16'h000A, 16'h0003, 16'h000F, 16'h0000));
        send(4, 0, mk(16'hA, 16'h3, 16'hF, 16'h0), 4, 4);
        check("unsigned_valid_next", o_row_valid, 1);
        cycles(2);

        exp_q.push_back(mk(16'hFFFA, 16'h0005, 16'hFFF8, 16'h0007));
        send(4, 1, mk(16'hA, 16'h5, 16'h8, 16'h7), 4, 4);
        cycles(2);

        exp_q.push_back(mk(16'h0001, 16'h0000, 16'h0001, 16'h0000));
        send(0, 0, mk(16'h1, 16'h0, 16'h1, 16'h0), 1, 1);
        check("p1_single_beat", o_row_valid, 1);
        cycles(2);
        exp_q.push_back(mk(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000));
        send(0, 1, mk(16'h1, 16'h0, 16'h1, 16'h0), 1, 1);
        cycles(2);

        l = mk(16'h8001, 16'h1234, 16'hFFFF, 16'h0F0F);
        exp_q.push_back(l);
        send(20, 1, l, 16, 15);
        check("clamp_not_early", o_row_valid, 0);
        beat(bits_at(l, 0), 1'b0, 20, 1'b1);
        check("clamp_done_16", o_row_valid, 1);
        cycles(2);

        i_row_ready = 1'b0;
        r1 = mk(16'h1, 16'h2, 16'h3, 16'h0);
        r2 = mk(16'h3, 16'h3, 16'h1, 16'h1);
        exp_q.push_back(r1);
        exp_q.push_back(r2);
        send(2, 0, r1, 2, 2);
        send(2, 0, r2, 2, 2);
        check("bp_ready_low", o_ready, 0);
        check("bp_err_before", o_err, 0);
        beat(4'hF, 1'b1, 2, 1'b0);
        check("bp_err_set", o_err, 1);
        check("bp_ready_still_low", o_ready, 0);
        check("bp_row_first", o_row, r1);
        cycles(3);
        check("bp_row_hold", o_row, r1);
        i_row_ready = 1'b1;
        cycles(3);
        check("bp_ready_back", o_ready, 1);
        check("bp_drained", exp_q.size(), 0);

        exp_q.push_back(mk(16'h0005, 16'h0003, 16'h0006, 16'h0000));
        send(4, 0, mk(16'hF, 16'hF, 16'hF, 16'hF), 4, 2);
        send(3, 0, mk(16'h5, 16'h3, 16'h6, 16'h0), 3, 3);
        cycles(3);
        check("restart_drained", exp_q.size(), 0);

        // The FULL row and the partial group are both dropped by reset, so nothing is queued.
        i_row_ready = 1'b0;
        send(2, 0, mk(16'h1, 16'h1, 16'h1, 16'h1), 2, 2);
        send(4, 0, mk(16'h9, 16'h9, 16'h9, 16'h9), 4, 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", o_ready, 1);
        check("mid_rst_row_valid", o_row_valid, 0);
        check("mid_rst_row", o_row, 0);
        check("mid_rst_err", o_err, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        i_row_ready = 1'b1;
        cycles(4);
        check("post_rst_no_row", o_row_valid, 0);
        exp_q.push_back(mk(16'h000C, 16'h0000, 16'h0007, 16'h0001));
        send(4, 0, mk(16'hC, 16'h0, 16'h7, 16'h1), 4, 4);
        cycles(2);
        check("post_rst_drained", exp_q.size(), 0);

        i_row_ready = 1'b0;
        ra = mk(16'h2, 16'h1, 16'h0, 16'h3);
        rb = mk(16'h1, 16'h3, 16'h2, 16'h0);
        exp_q.push_back(ra);
        exp_q.push_back(rb);
        send(2, 0, ra, 2, 2);
        send(2, 0, rb, 2, 1);
        i_row_ready = 1'b1;
        beat(bits_at(rb, 0), 1'b0, 2, 1'b0);
        check("conc_ready", o_ready, 1);
        check("conc_row_valid", o_row_valid, 1);
        check("conc_row_b", o_row, rb);
        cycles(3);

        check("idle_err_before", o_err, 0);
        beat(4'hF, 1'b0, 4, 1'b0);
        check("idle_nostart_err", o_err, 1);
        cycles(4);
        check("idle_nostart_no_row", o_row_valid, 0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycles(1);
        check("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
